// File: rtl/mod_mul_pipe.sv
// mod_mul_pipe: 3-stage Barrett modular multiplier for the Kyber modulus.
// S1 pre-reduces the operands and multiplies them, S2 estimates the quotient,
// S3 subtracts and applies the final correction. The whole pipe advances on
// a single global enable, so entries never reorder and a stall freezes them all.
module mod_mul_pipe #(
    parameter int Q          = 3329,
    parameter int BARRETT_M  = 5039,
    parameter int BARRETT_SH = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic [1:0]  tag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] res,
    output logic [1:0]  tag_out,
    output logic        busy
);

    // Stage registers (data regs carry no reset; the valid bits gate everything)
    logic        r_v1, r_v2, r_ov;
    logic [23:0] r_p1, r_p2;
    logic [12:0] r_qe;
    logic [1:0]  r_t1, r_t2, r_tag_out;
    logic [11:0] r_res;

    logic        w_adv, w_in_xfer;
    logic [11:0] w_ar, w_br;
    logic [12:0] w_r;
    logic [11:0] w_res;

    // Global advance: the output slot is empty or is being consumed
    assign w_adv     = !r_ov || out_ready;
    assign in_ready  = w_adv && !rst;
    assign w_in_xfer = in_valid && in_ready;

    // Operands may be up to 4095, i.e. at most one Q above the residue range
    assign w_ar = (a >= 12'(Q)) ? a - 12'(Q) : a;
    assign w_br = (b >= 12'(Q)) ? b - 12'(Q) : b;

    // Barrett remainder lands in 0..2Q-1, so a single conditional subtract suffices
    assign w_r   = 13'(25'(r_p2) - 25'(r_qe) * 25'(Q));
    assign w_res = (w_r >= 13'(Q)) ? 12'(w_r - 13'(Q)) : w_r[11:0];

    // Valid bits and output registers: cleared by reset, shifted on advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_ov      <= 1'b0;
            r_res     <= '0;
            r_tag_out <= '0;
        end else if (w_adv) begin
            r_v1      <= w_in_xfer;
            r_v2      <= r_v1;
            r_ov      <= r_v2;
            r_res     <= w_res;
            r_tag_out <= r_t2;
        end
    end

    // Data path registers: no reset, hold whenever the pipe is stalled
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_p1 <= 24'(w_ar) * 24'(w_br);
            r_t1 <= tag;
            r_p2 <= r_p1;
            // full 37-bit product before the shift so the estimate is never low by more than one
            r_qe <= 13'((37'(r_p1) * 37'(BARRETT_M)) >> BARRETT_SH);
            r_t2 <= r_t1;
        end
    end

    assign out_valid = r_ov;
    assign res       = r_res;
    assign tag_out   = r_tag_out;
    assign busy      = r_v1 || r_v2 || r_ov;

endmodule

// File: tb/tb_mod_mul_pipe.sv
// Bench for mod_mul_pipe: directed literal vectors plus a queue-based
// reference model (plain % arithmetic) checked on every negedge.
module tb_mod_mul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] a = '0, b = '0;
    logic [1:0]  tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] res;
    logic [1:0]  tag_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct { int r; int t; } exp_t;
    exp_t q[$];

    mod_mul_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .tag(tag), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .tag_out(tag_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int mmod(input int x, input int y);
        return ((x % 3329) * (y % 3329)) % 3329;
    endfunction

    task automatic drive(input logic v, input int x, input int y, input int t);
        in_valid = v; a = 12'(x); b = 12'(y); tag = 2'(t);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Reference model and per-cycle compare
    logic        prev_stall = 1'b0;
    logic [11:0] prev_res;
    logic [1:0]  prev_tag;
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            chk("in_ready_in_reset", int'(in_ready), 0);
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
            if (prev_stall) begin
                chk("stall_valid_hold", int'(out_valid), 1);
                chk("stall_res_hold", int'(res), int'(prev_res));
                chk("stall_tag_hold", int'(tag_out), int'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("model_res", int'(res), q[0].r);
                    chk("model_tag", int'(tag_out), q[0].t);
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready)
                q.push_back('{mmod(int'(a), int'(b)), int'(tag)});
            prev_stall = out_valid && !out_ready;
            prev_res   = res;
            prev_tag   = tag_out;
        end
    end

    int          held;
    int          budget;
    initial begin
        // Reset state
        step(); step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res", int'(res), 0);
        chk("rst_tag_out", int'(tag_out), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", int'(in_ready), 1);

        // Max residues, 3-cycle latency
        drive(1, 3328, 3328, 1); step();
        drive(0, 0, 0, 0);
        chk("lat_c1_valid", int'(out_valid), 0); step();
        chk("lat_c2_valid", int'(out_valid), 0); step();
        chk("lat_c3_valid", int'(out_valid), 1);
        chk("lat_c3_res", int'(res), 1);
        chk("lat_c3_tag", int'(tag_out), 1);
        step(); step();

        // Back-to-back inputs
        drive(1, 1665, 2, 2); step();
        drive(1, 0, 1234, 3); step();
        drive(1, 17, 1, 0); step();
        drive(0, 0, 0, 0);
        chk("b2b_0_res", int'(res), 1);    chk("b2b_0_v", int'(out_valid), 1); step();
        chk("b2b_1_res", int'(res), 0);    chk("b2b_1_v", int'(out_valid), 1); step();
        chk("b2b_2_res", int'(res), 17);   chk("b2b_2_v", int'(out_valid), 1); step();
        chk("b2b_done_v", int'(out_valid), 0);

        // Pre-reduction of operands >= Q
        drive(1, 4000, 1, 1); step();
        drive(1, 3329, 3329, 2); step();
        drive(0, 0, 0, 0); step();
        chk("pre_4000_res", int'(res), 671); step();
        chk("pre_3329_res", int'(res), 0);
        step(); step();

        // Backpressure: fill the pipe, hold, then drain
        out_ready = 1'b0;
        drive(1, 5, 7, 1); step();
        drive(1, 100, 100, 2); step();
        drive(1, 4095, 4095, 3); step();
        drive(1, 1, 1, 0);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_busy", int'(busy), 1);
        chk("bp_valid", int'(out_valid), 1);
        held = int'(res);
        chk("bp_first_res", held, 35);
        for (int i = 0; i < 10; i++) step();
        chk("bp_res_stable", int'(res), held);
        chk("bp_in_ready_10", int'(in_ready), 0);
        drive(0, 0, 0, 0);
        out_ready = 1'b1; step();
        chk("drain_1_res", int'(res), 13);  chk("drain_1_v", int'(out_valid), 1); step();
        chk("drain_2_res", int'(res), 852); chk("drain_2_v", int'(out_valid), 1); step();
        chk("drain_done_v", int'(out_valid), 0);

        // Reset mid-operation with two entries in flight
        drive(1, 10, 10, 1); step();
        drive(1, 20, 20, 2); step();
        drive(1, 30, 30, 3);
        rst = 1'b1; step();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        for (int i = 0; i < 6; i++) step();
        chk("midrst_no_stale", int'(out_valid), 0);

        // First input after reset appears 3 cycles later
        drive(1, 2, 3, 2); step();
        drive(0, 0, 0, 0); step(); step();
        chk("post_rst_res", int'(res), 6);
        chk("post_rst_v", int'(out_valid), 1);
        step();

        // Random sweep with random backpressure
        for (int i = 0; i < 4000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, 4095),
                  $urandom_range(0, 4095), $urandom_range(0, 3));
            out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end
        drive(0, 0, 0, 0);
        out_ready = 1'b1;
        budget = 0;
        while ((q.size() != 0 || busy) && budget < 50) begin
            step();
            budget++;
        end
        chk("drain_timeout", int'(budget < 50), 1);
        chk("final_queue_empty", q.size(), 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
